// File: rtl/uart_relay_pkg.sv
// Shared types and defaults for the UART line relay.
// Optional build macro used by the top: UART_LINE_RELAY_ECHO_EN (per-byte echo).
package uart_relay_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 1024;
  localparam logic [7:0] DEF_TERM_CHAR = 8'h0D;

  // Width needed to hold a count in the range 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line storage: one write port, one registered read port.
// Read data appears the cycle after rd_addr is presented.
module line_buffer_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_line_relay.sv
// Store-and-forward line relay: buffers received bytes, replays the line on send.
// Define UART_LINE_RELAY_ECHO_EN to echo accepted bytes and add the echo_drop output.
module uart_line_relay
  import uart_relay_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(DEF_TERM_CHAR),
  parameter int                AUTO_SEND = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             rx_byte,
  input  logic                          rx_valid,
  input  logic                          send_req,
  output logic [DATA_W-1:0]             tx_byte,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [cnt_width(DEPTH)-1:0]   fill_count,
  output logic                          sending,
  output logic                          overflow,
  output logic [DATA_W-1:0]             last_byte
`ifdef UART_LINE_RELAY_ECHO_EN
  ,
  output logic                          echo_drop
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t state, state_nxt;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              send_q;

  logic send_edge;
  logic accept;
  logic drop;
  logic trigger;
  logic go_fetch;
  logic load;
  logic done_byte;
  logic last_done;

`ifdef UART_LINE_RELAY_ECHO_EN
  logic armed;
  logic arm_set;
  logic echo_fire;
  logic echo_skip;
`endif

  line_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .wr_addr (wr_ptr),
    .wr_data (rx_byte),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign sending = (state != IDLE);

  always_comb begin
    state_nxt = state;
    send_edge = send_req & ~send_q;
    accept    = 1'b0;
    drop      = rx_valid && (state != IDLE);
    trigger   = 1'b0;
    go_fetch  = 1'b0;
    load      = 1'b0;
    done_byte = 1'b0;
    last_done = 1'b0;
`ifdef UART_LINE_RELAY_ECHO_EN
    arm_set   = 1'b0;
    echo_fire = 1'b0;
    echo_skip = 1'b0;
`endif

    case (state)
      IDLE: begin
        accept  = rx_valid && (fill_count != FULL);
        drop    = rx_valid && (fill_count == FULL);
        // A dropped terminator still arms the send of what is already stored.
        trigger = send_edge || ((AUTO_SEND != 0) && rx_valid && (rx_byte == TERM_CHAR));
`ifdef UART_LINE_RELAY_ECHO_EN
        echo_fire = accept && !tx_busy;
        echo_skip = accept && tx_busy;
        if ((trigger || armed) && (accept || (fill_count != '0))) begin
          if (tx_busy || tx_start || echo_fire) arm_set = 1'b1;
          else                                  go_fetch = 1'b1;
        end
`else
        go_fetch = trigger && (accept || (fill_count != '0));
`endif
        if (go_fetch) state_nxt = FETCH;
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        load      = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_byte = 1'b1;
          if (CNT_W'(rd_ptr) + CNT_W'(1) == fill_count) begin
            last_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
      tx_start   <= 1'b0;
      tx_byte    <= '0;
      overflow   <= 1'b0;
      last_byte  <= '0;
      // Starts high so a button held through reset does not fire.
      send_q     <= 1'b1;
`ifdef UART_LINE_RELAY_ECHO_EN
      echo_drop  <= 1'b0;
      armed      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      send_q   <= send_req;
      tx_start <= 1'b0;

      if (accept) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        fill_count <= fill_count + CNT_W'(1);
        last_byte  <= rx_byte;
      end
      if (go_fetch)  rd_ptr <= '0;
      if (load) begin
        tx_byte  <= rd_data;
        tx_start <= 1'b1;
      end
      if (done_byte) rd_ptr <= rd_ptr + PTR_W'(1);
      if (last_done) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fill_count <= '0;
        overflow   <= 1'b0;
      end
      if (drop) overflow <= 1'b1;

`ifdef UART_LINE_RELAY_ECHO_EN
      if (echo_fire) begin
        tx_byte  <= rx_byte;
        tx_start <= 1'b1;
      end
      if (echo_skip) echo_drop <= 1'b1;
      if (last_done) echo_drop <= 1'b0;
      if (arm_set)   armed <= 1'b1;
      if (go_fetch)  armed <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_line_relay.sv
// Self-checking bench: two relays (DEPTH 8 manual send, DEPTH 4 auto send)
// against a line-level queue model and a randomised transmitter responder.
module tb_uart_line_relay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] rx_byte   [2];
  logic       rx_valid  [2];
  logic       send_req  [2];
  logic       tx_start  [2];
  logic       tx_busy   [2];
  logic       sending   [2];
  logic       overflow  [2];
  logic [7:0] tx_byte   [2];
  logic [7:0] last_byte [2];
  logic [3:0] fc0;
  logic [2:0] fc1;

  uart_line_relay #(.DATA_W(8), .DEPTH(8), .TERM_CHAR(8'h0D), .AUTO_SEND(0)) u0 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte[0]), .rx_valid(rx_valid[0]),
    .send_req(send_req[0]), .tx_byte(tx_byte[0]), .tx_start(tx_start[0]),
    .tx_busy(tx_busy[0]), .fill_count(fc0), .sending(sending[0]),
    .overflow(overflow[0]), .last_byte(last_byte[0]));

  uart_line_relay #(.DATA_W(8), .DEPTH(4), .TERM_CHAR(8'h0D), .AUTO_SEND(1)) u1 (
    .clk(clk), .rst(rst), .rx_byte(rx_byte[1]), .rx_valid(rx_valid[1]),
    .send_req(send_req[1]), .tx_byte(tx_byte[1]), .tx_start(tx_start[1]),
    .tx_busy(tx_busy[1]), .fill_count(fc1), .sending(sending[1]),
    .overflow(overflow[1]), .last_byte(last_byte[1]));

  int tests = 0;
  int fails = 0;

  logic [7:0] got0[$], got1[$];
  logic [7:0] mbuf0[$], mbuf1[$];
  logic       movf  [2];
  logic [7:0] mlast [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fill(input int k);
    return (k == 0) ? 32'(fc0) : 32'(fc1);
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  // Transmitter responder: records each started byte, then goes busy after a random gap.
  int         tst [2];
  int         twt [2];
  int         tln [2];
  logic [7:0] tcur [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        tx_busy[k] = 1'b0;
        tst[k] = 0;
      end else begin
        case (tst[k])
          0: if (tx_start[k] === 1'b1) begin
               if (k == 0) got0.push_back(tx_byte[k]);
               else        got1.push_back(tx_byte[k]);
               tcur[k] = tx_byte[k];
               twt[k]  = $urandom_range(0, 2);
               tln[k]  = $urandom_range(2, 4);
               tst[k]  = 1;
             end
          1: if (twt[k] == 0) begin
               tx_busy[k] = 1'b1;
               tst[k] = 2;
             end else twt[k]--;
          default: if (tln[k] == 0) begin
               tx_busy[k] = 1'b0;
               check("tx_byte_stable", 32'(tx_byte[k]), 32'(tcur[k]));
               tst[k] = 0;
             end else tln[k]--;
        endcase
      end
    end
  end

  // Line model: bytes are kept while there is room, otherwise overflow is flagged.
  task automatic m_rx(input int k, input logic [7:0] b);
    int n;
    n = (k == 0) ? mbuf0.size() : mbuf1.size();
    if (n < depth_of(k)) begin
      if (k == 0) mbuf0.push_back(b);
      else        mbuf1.push_back(b);
      mlast[k] = b;
    end else begin
      movf[k] = 1'b1;
    end
  endtask

  task automatic drive_rx(input int k, input logic [7:0] b);
    @(negedge clk);
    rx_byte[k]  = b;
    rx_valid[k] = 1'b1;
    m_rx(k, b);
    @(negedge clk);
    rx_valid[k] = 1'b0;
  endtask

  task automatic press(input int k);
    @(negedge clk);
    send_req[k] = 1'b1;
    @(negedge clk);
    send_req[k] = 1'b0;
  endtask

  task automatic model_clear(input int k);
    if (k == 0) begin mbuf0.delete(); got0.delete(); end
    else        begin mbuf1.delete(); got1.delete(); end
    movf[k] = 1'b0;
  endtask

  // Waits for the line to drain, then compares the replayed bytes with the model.
  task automatic finish_send(input int k, input string tag);
    int n;
    logic [7:0] g[$], e[$];
    check({tag, "_started"}, 32'(sending[k]), 32'd1);
    n = 0;
    while (sending[k] === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
    if (k == 0) begin g = got0; e = mbuf0; end
    else        begin g = got1; e = mbuf1; end
    check({tag, "_count"}, 32'(g.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < g.size(); i++)
      check({tag, "_byte"}, 32'(g[i]), 32'(e[i]));
    check({tag, "_fill"}, fill(k), 32'd0);
    check({tag, "_ovf"}, 32'(overflow[k]), 32'd0);
    model_clear(k);
  endtask

  initial begin
    int n;
    int seen;
    logic [7:0] b;

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rx_byte[k] = 8'h00; rx_valid[k] = 1'b0; send_req[k] = 1'b0;
      movf[k] = 1'b0; mlast[k] = 8'h00;
    end
    send_req[0] = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      check("rst_fill", fill(k), 32'd0);
      check("rst_sending", 32'(sending[k]), 32'd0);
      check("rst_ovf", 32'(overflow[k]), 32'd0);
      check("rst_last", 32'(last_byte[k]), 32'd0);
      check("rst_tx_byte", 32'(tx_byte[k]), 32'd0);
      check("rst_tx_start", 32'(tx_start[k]), 32'd0);
    end

    // Release reset with send_req still held and a byte arriving on the first cycle.
    rst = 1'b0;
    rx_byte[0] = 8'h11; rx_valid[0] = 1'b1; m_rx(0, 8'h11);
    @(negedge clk);
    rx_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("held_no_send", 32'(sending[0]), 32'd0);
    check("held_fill", fill(0), 32'd1);
    check("held_last", 32'(last_byte[0]), 32'h11);
    send_req[0] = 1'b0;
    @(negedge clk);
    press(0);
    finish_send(0, "after_reset");

    // Manual send of "ABC".
    drive_rx(0, 8'h41); drive_rx(0, 8'h42); drive_rx(0, 8'h43);
    check("abc_fill", fill(0), 32'd3);
    check("abc_last", 32'(last_byte[0]), 32'h43);
    press(0);
    finish_send(0, "abc");

    // Terminator-triggered send, terminator included.
    drive_rx(1, 8'h48); drive_rx(1, 8'h69); drive_rx(1, 8'h0D);
    finish_send(1, "auto");

    // Overflow on a 4-deep buffer.
    for (int i = 1; i <= 5; i++) drive_rx(1, 8'(i));
    check("full_fill", fill(1), 32'd4);
    check("full_ovf", 32'(overflow[1]), 32'd1);
    check("full_last", 32'(last_byte[1]), 32'h04);
    press(1);
    finish_send(1, "full");

    // Byte and send edge arriving mid-send are both ignored.
    for (int i = 0; i < 3; i++) drive_rx(0, 8'($urandom_range(0, 255)));
    press(0);
    n = 0;
    while (got0.size() == 0 && n < 200) begin @(negedge clk); n++; end
    check("midsend_wait", 32'(n < 200), 32'd1);
    rx_byte[0] = 8'h55; rx_valid[0] = 1'b1; send_req[0] = 1'b1;
    @(negedge clk);
    rx_valid[0] = 1'b0;
    check("midsend_ovf", 32'(overflow[0]), 32'd1);
    check("midsend_last", 32'(last_byte[0]), 32'(mlast[0]));
    @(negedge clk);
    send_req[0] = 1'b0;
    finish_send(0, "midsend");
    seen = 0;
    repeat (30) begin @(negedge clk); if (sending[0] === 1'b1) seen++; end
    check("midsend_one_send", 32'(seen + got0.size()), 32'd0);

    // Send edge with an empty buffer does nothing.
    press(0);
    seen = 0;
    repeat (10) begin @(negedge clk); if (sending[0] === 1'b1 || tx_start[0] === 1'b1) seen++; end
    check("empty_no_send", 32'(seen + got0.size()), 32'd0);

    // Reset while waiting for completion of byte 2 of 5.
    for (int i = 0; i < 5; i++) drive_rx(0, 8'($urandom_range(0, 255)));
    press(0);
    n = 0;
    while (!(got0.size() == 2 && tx_busy[0] === 1'b1) && n < 500) begin @(negedge clk); n++; end
    check("rst_mid_wait", 32'(n < 500), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_sending", 32'(sending[0]), 32'd0);
    check("rst_mid_fill", fill(0), 32'd0);
    check("rst_mid_tx_start", 32'(tx_start[0]), 32'd0);
    rst = 1'b0;
    model_clear(0);
    mlast[0] = 8'h00; mlast[1] = 8'h00;
    drive_rx(0, 8'h7A);
    press(0);
    finish_send(0, "after_mid_rst");

    // Random lines on both relays, including terminator-triggered and overflowing ones.
    for (int it = 0; it < 10; it++) begin
      int k;
      int len;
      k   = it % 2;
      len = $urandom_range(1, depth_of(k) + 2);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0D) b = 8'h0E;
        if (k == 1 && (it % 4) == 1 && i == len - 1) b = 8'h0D;
        drive_rx(k, b);
      end
      if (!(k == 1 && (it % 4) == 1)) begin
        check("rnd_fill", fill(k), 32'((len < depth_of(k)) ? len : depth_of(k)));
        check("rnd_ovf", 32'(overflow[k]), 32'(movf[k]));
        check("rnd_last", 32'(last_byte[k]), 32'(mlast[k]));
        press(k);
      end
      finish_send(k, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_line_relay.md
Name: uart_line_relay

Overview:
Parametrised store-and-forward line buffer between a UART receiver byte stream and a UART transmitter byte interface. Received bytes accumulate in an internal synchronous RAM. The whole line is replayed to the transmitter on a send request, or automatically on a terminator byte. This generation adds configurable width and depth, edge-detected send, terminator-triggered send, overflow reporting and exact byte-count replay.

Parameters:
DATA_W, 8, width of each stored/transmitted byte
DEPTH, 1024, line buffer capacity in bytes (any value >= 2)
TERM_CHAR, 8'h0D, terminator byte value (compared on DATA_W bits)
AUTO_SEND, 1, 1 = receipt of TERM_CHAR triggers send; 0 = send_req only

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_byte  in  DATA_W  received byte
rx_valid  in  1  one-cycle strobe, rx_byte valid
send_req  in  1  debounced level; rising edge requests send
tx_byte  out  DATA_W  byte to transmitter, stable from tx_start until tx_busy falls
tx_start  out  1  one-cycle pulse to transmitter
tx_busy  in  1  transmitter busy
fill_count  out  $clog2(DEPTH+1)  bytes currently stored
sending  out  1  high in any non-IDLE state
overflow  out  1  sticky; byte dropped since last completed send
last_byte  out  DATA_W  most recently accepted byte, for debug display

Behaviour:
- Reset: state IDLE; wr_ptr, rd_ptr, fill_count = 0; tx_start = 0; tx_byte = 0; overflow = 0; last_byte = 0; send_req edge register = 1, so a held button does not fire after reset.
- RAM: written when a byte is accepted. Synchronous read with 1-cycle latency: data is valid the cycle after rd_ptr is presented.
- States: IDLE, FETCH, LOAD, WAIT_ACK, WAIT_DONE.
- IDLE, byte acceptance: rx_valid with fill_count < DEPTH writes to RAM[wr_ptr], then wr_ptr++, fill_count++, last_byte <= rx_byte.
- IDLE, full buffer: rx_valid with fill_count == DEPTH drops the byte and sets overflow.
- IDLE, send trigger: a send_req rising edge, or (AUTO_SEND and an accepted-or-dropped rx_byte == TERM_CHAR), arms a send.
  - If fill_count (including a same-cycle accepted byte) is > 0, go to FETCH with rd_ptr = 0.
  - Otherwise the trigger is ignored.
- Simultaneous rx_valid and send edge in IDLE: the byte is accepted first and is included in the send.
- FETCH: present rd_ptr; go to LOAD next cycle.
- LOAD: tx_byte <= RAM data; tx_start pulses 1 cycle; go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy == 1, then go to WAIT_DONE. No timeout.
- WAIT_DONE: on tx_busy == 0, rd_ptr++.
  - If rd_ptr+1 == fill_count: go to IDLE; wr_ptr, rd_ptr, fill_count cleared; overflow cleared.
  - Otherwise go to FETCH.
- Exactly fill_count bytes are sent, in write order.
- While sending: rx_valid bytes are dropped and set overflow, and send edges are ignored. last_byte is unchanged.
- Reset mid-send: tx_start = 0 on the following cycle and the buffer is emptied. An in-flight transmitter byte is not aborted; that is the transmitter's responsibility.
- Widths: pointers are $clog2(DEPTH) bits and never wrap, because they clear each line; fill_count saturates at DEPTH.

Optional Feature:
Macro UART_LINE_RELAY_ECHO_EN.
- Defined: in IDLE, each accepted byte is also echoed immediately.
  - Echo occurs only if tx_busy == 0 that cycle; tx_byte <= rx_byte and tx_start pulses.
  - If tx_busy == 1, the echo is skipped and echo_drop (an extra 1-bit sticky output) is set. echo_drop is cleared on send completion.
  - A send trigger arriving while an echo is in flight enters FETCH only after tx_busy == 0.
- Undefined: no echo; echo_drop port absent; IDLE never drives tx_start.

Decomposition:
- Package uart_relay_pkg holds:
  - the state_t enum (logic [2:0]: IDLE, FETCH, LOAD, WAIT_ACK, WAIT_DONE)
  - default DATA_W/DEPTH/TERM_CHAR localparams
  - a count-width function wrapping $clog2(DEPTH+1)
- One sub-module, line_buffer_ram: simple dual-port synchronous RAM with parametrised DATA_W/DEPTH, one write port and one registered read port.

Test Plan:
- Reset then rx "A","B","C" (41,42,43), AUTO_SEND=0, send_req rise -> tx_start fires 3 times with 41,42,43. fill_count goes 3 -> 0. No 4th byte is sent.
- AUTO_SEND=1, rx 48,69,0D -> send starts without send_req; 3 bytes sent, including 0D; sending then low, overflow 0.
- DEPTH=4: rx 5 bytes 01..05 -> fill_count 4, overflow 1. send_req -> 01..04 sent; overflow clears after the last byte completes.
- During send of a 3-byte line, pulse rx_valid with 55 and raise send_req again -> 55 not stored, overflow 1, only the original 3 bytes sent, one send total.
- Send_req held high across reset and released then re-pressed -> no send after reset; exactly one send per rising edge. Edge with empty buffer -> no tx_start.
- Assert rst while in WAIT_DONE on byte 2 of 5 -> next cycle: sending 0, fill_count 0, tx_start 0. Subsequent rx 7A and send -> only 7A sent.
